apb4_req_master: RTL and testbench
==================================

// Module: apb4_req_master
// PURPOSE
//  Parametrised APB4 (v2.0) master: turns a valid/ready request channel into single APB4
//  transfers and returns the result on a valid/ready response channel.
//  Adds a per-transfer wait-state timeout with abort and error report.
//  Sits between an internal bus adapter and an APB4 slave segment. The APB side uses the
//  Master modport signal set.
// PARAMETERS
//  ADDR_WIDTH      32  APB address width (paddr_o, req_addr_i)
//  DATA_WIDTH      32  APB data width; any multiple of 8, 8..1024
//  STRB_WIDTH      ceil(DATA_WIDTH/8)  derived localparam, not overridable
//  TIMEOUT_CYCLES  256 max ACCESS cycles with pready_i=0 before abort; 0 disables timeout
// PORTS
//  clk_i          in   1           clock, all logic on rising edge
//  rst_i          in   1           reset
//  req_valid_i    in   1           request valid
//  req_ready_o    out  1           request accepted when valid&ready
//  req_addr_i     in   ADDR_WIDTH  transfer address
//  req_write_i    in   1           1=write, 0=read
//  req_wdata_i    in   DATA_WIDTH  write data
//  req_strb_i     in   STRB_WIDTH  write byte strobes
//  req_prot_i     in   3           protection (apb_pkg::prot_t encoding)
//  rsp_valid_o    out  1           response valid
//  rsp_ready_i    in   1           response consumed when valid&ready
//  rsp_rdata_o    out  DATA_WIDTH  read data; 0 for writes and timeouts
//  rsp_err_o      out  1           pslverr_i sampled, or timeout
//  rsp_timeout_o  out  1           transfer aborted by timeout
//  paddr_o, pprot_o, psel_o, penable_o, pwrite_o, pwdata_o, pstrb_o   out  APB4 master request
//  pready_i, prdata_i, pslverr_i                                      in   APB4 slave response
// BEHAVIOUR
//  Clocking/reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
//  Reset values: every output 0; FSM in IDLE; timeout counter 0.
//  All APB outputs and rsp_* outputs are driven from flops.
//  FSM states: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//   IDLE: req_ready_o=1. On req_valid_i, capture addr/write/wdata/strb/prot.
//     pstrb_o = req_write_i ? req_strb_i : 0. pwdata_o = req_write_i ? req_wdata_i : 0.
//     Go to SETUP.
//   SETUP: psel_o=1, penable_o=0. Always go to ACCESS.
//   ACCESS: psel_o=1, penable_o=1; wait for pready_i.
//     pready_i=1: capture prdata_i (reads only, else 0) and pslverr_i into rsp_err_o.
//       Set rsp_timeout_o=0. Drop psel_o/penable_o. Go to RESP.
//     pready_i=0 with TIMEOUT_CYCLES!=0: increment the counter. When it reaches
//       TIMEOUT_CYCLES, abort: psel_o=penable_o=0, rsp_err_o=1, rsp_timeout_o=1,
//       rsp_rdata_o=0. Go to RESP.
//     A pready_i that coincides with the terminal count wins: normal completion, no timeout.
//   RESP: rsp_valid_o=1, response fields held stable. On rsp_ready_i go to IDLE, clear the
//     counter, deassert rsp_valid_o. Back-to-back requests are allowed from the next cycle.
//  Latency: accept at edge T; SETUP visible after T; ACCESS after T+1.
//   Zero-wait slave: rsp_valid_o high after T+2. Minimum 4 cycles per transfer.
//  Stability: paddr/pprot/pwrite/pwdata/pstrb stay constant from SETUP until ACCESS ends.
//   They keep their value in IDLE/RESP (no toggling); psel_o is the only qualifier.
//  req_ready_o=0 in SETUP/ACCESS/RESP; at most one transfer is outstanding.
//  Counter width is $clog2(TIMEOUT_CYCLES+1); the counter saturates and never wraps.
//  Reset mid-transfer: psel_o/penable_o/rsp_valid_o are 0 from the next edge.
//   The in-flight request is dropped with no response.
//  pready_i/prdata_i/pslverr_i are ignored outside ACCESS.
// TESTING
//  1 Write 0x1000 data 0xDEADBEEF strb 0xF, slave pready=1 at once -> SETUP/ACCESS each
//    1 cycle, pstrb=0xF, rsp_valid after T+2, err=0.
//  2 Read 0x2004, slave 3 wait states, prdata=0x12345678 -> penable held 4 cycles,
//    pstrb=0, rsp_rdata=0x12345678, paddr stable throughout.
//  3 Write with pslverr=1 at pready -> rsp_err=1, rsp_timeout=0, next request accepted
//    the cycle after rsp handshake.
//  4 TIMEOUT_CYCLES=4, pready never rises -> abort after 4 ACCESS cycles, rsp_err=1,
//    rsp_timeout=1, rdata=0. Also: pready on 4th cycle -> normal completion.
//  5 rsp_ready held 0 for 10 cycles -> rsp fields stable, req_ready=0, no new psel.
//  6 rst_i asserted in ACCESS -> all outputs 0 next edge, IDLE; a following request
//    completes normally.

Source files
------------

// File: rtl/apb4_req_master.sv
// apb4_req_master: bridges a valid/ready request channel onto single APB4
// transfers and returns each result on a valid/ready response channel.
// A per-transfer wait-state timeout aborts a slave that never raises pready.
module apb4_req_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    // request channel
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    input  logic [ADDR_WIDTH-1:0]       req_addr_i,
    input  logic                        req_write_i,
    input  logic [DATA_WIDTH-1:0]       req_wdata_i,
    input  logic [(DATA_WIDTH+7)/8-1:0] req_strb_i,
    input  logic [2:0]                  req_prot_i,
    // response channel
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [DATA_WIDTH-1:0]       rsp_rdata_o,
    output logic                        rsp_err_o,
    output logic                        rsp_timeout_o,
    // APB4 master side
    output logic [ADDR_WIDTH-1:0]       paddr_o,
    output logic [2:0]                  pprot_o,
    output logic                        psel_o,
    output logic                        penable_o,
    output logic                        pwrite_o,
    output logic [DATA_WIDTH-1:0]       pwdata_o,
    output logic [(DATA_WIDTH+7)/8-1:0] pstrb_o,
    input  logic                        pready_i,
    input  logic [DATA_WIDTH-1:0]       prdata_i,
    input  logic                        pslverr_i
);

    localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8;

    // A zero timeout still needs a legal one-bit counter; it simply never counts.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    // Abort fires on the ACCESS cycle that would bring the count up to TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             accept;
    logic             done;
    logic             abort;

    // Next-state, wait counter and transfer events for the current cycle.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        done       = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                // req_ready_o is registered, so it also gates the cycle right after reset.
                if (req_valid_i && req_ready_o) begin
                    accept     = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                state_next = ACCESS;
            end
            ACCESS: begin
                // pready wins over a coincident terminal count.
                if (pready_i) begin
                    done       = 1'b1;
                    state_next = RESP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
                    if (cnt == CNT_TERM) begin
                        abort      = 1'b1;
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and wait-counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Registered outputs: handshake/qualifiers follow the next state, APB
    // attributes load only on accept and response fields only on completion.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            req_ready_o   <= 1'b0;
            psel_o        <= 1'b0;
            penable_o     <= 1'b0;
            rsp_valid_o   <= 1'b0;
            paddr_o       <= '0;
            pprot_o       <= '0;
            pwrite_o      <= 1'b0;
            pwdata_o      <= '0;
            pstrb_o       <= '0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            rsp_timeout_o <= 1'b0;
        end else begin
            req_ready_o <= (state_next == IDLE);
            psel_o      <= (state_next == SETUP) || (state_next == ACCESS);
            penable_o   <= (state_next == ACCESS);
            rsp_valid_o <= (state_next == RESP);

            if (accept) begin
                paddr_o  <= req_addr_i;
                pprot_o  <= req_prot_i;
                pwrite_o <= req_write_i;
                pwdata_o <= req_write_i ? req_wdata_i : '0;
                pstrb_o  <= req_write_i ? req_strb_i : STRB_WIDTH'(0);
            end

            if (done) begin
                rsp_rdata_o   <= pwrite_o ? '0 : prdata_i;
                rsp_err_o     <= pslverr_i;
                rsp_timeout_o <= 1'b0;
            end else if (abort) begin
                rsp_rdata_o   <= '0;
                rsp_err_o     <= 1'b1;
                rsp_timeout_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb4_req_master.sv
// tb_apb4_req_master: table-driven and randomized checks of apb4_req_master
// against a transaction-level expectation model and an in-bench APB slave.
module tb_apb4_req_master;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    apb4_req_master #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_write_i  (req_write),
        .req_wdata_i  (req_wdata),
        .req_strb_i   (req_strb),
        .req_prot_i   (req_prot),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .rsp_timeout_o(rsp_timeout),
        .paddr_o      (paddr),
        .pprot_o      (pprot),
        .psel_o       (psel),
        .penable_o    (penable),
        .pwrite_o     (pwrite),
        .pwdata_o     (pwdata),
        .pstrb_o      (pstrb),
        .pready_i     (pready),
        .prdata_i     (prdata),
        .pslverr_i    (pslverr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        int          waits;   // ACCESS cycles with pready low before the slave answers
        logic        slverr;
        logic [31:0] prdata;
        int          rdly;    // cycles the response is back-pressured
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int          exp_acc; // expected number of ACCESS cycles
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level expectation: a slave answering within TO ACCESS
    // cycles completes normally, otherwise the master gives up after TO cycles.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        if (v.waits < TO) begin
            r.exp_acc   = v.waits + 1;
            r.exp_rdata = v.wr ? 32'h0 : v.prdata;
            r.exp_err   = v.slverr;
            r.exp_to    = 1'b0;
        end else begin
            r.exp_acc   = TO;
            r.exp_rdata = 32'h0;
            r.exp_err   = 1'b1;
            r.exp_to    = 1'b1;
        end
        return r;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_wait", 64'(n < 20), 64'd1);
    endtask

    task automatic do_xfer(input vec_t v);
        int   k;
        logic ok;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        exp_strb  = v.wr ? v.strb : 4'h0;
        exp_wdata = v.wr ? v.wdata : 32'h0;

        req_write = v.wr;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        req_strb  = v.strb;
        req_prot  = v.prot;
        req_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        // Scramble the request bus so any late re-capture would show up.
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_strb  = 4'($urandom);
        req_write = ~v.wr;

        // SETUP phase
        check("setup_ctl", 64'({psel, penable, req_ready, rsp_valid}), 64'(4'b1000));
        check("setup_addr", 64'(paddr), 64'(v.addr));
        check("setup_attr", 64'({pwrite, pprot, pstrb}), 64'({v.wr, v.prot, exp_strb}));
        check("setup_wdata", 64'(pwdata), 64'(exp_wdata));
        @(posedge clk); #1;

        // ACCESS phase with the bench slave
        k  = 0;
        ok = 1'b1;
        while (!rsp_valid && k < 12) begin
            if (!(psel && penable) || paddr !== v.addr || pwrite !== v.wr ||
                pwdata !== exp_wdata || pstrb !== exp_strb || pprot !== v.prot)
                ok = 1'b0;
            k++;
            pready  = (k == v.waits + 1);
            prdata  = pready ? v.prdata : $urandom;
            pslverr = pready ? v.slverr : 1'($urandom);
            @(posedge clk); #1;
            pready  = 1'b0;
            prdata  = $urandom;
            pslverr = 1'($urandom);
        end
        check("access_cycles", 64'(k), 64'(v.exp_acc));
        check("access_stable", 64'(ok), 64'd1);

        // RESP phase
        check("rsp_ctl", 64'({rsp_valid, psel, penable, req_ready}), 64'(4'b1000));
        check("rsp_rdata", 64'(rsp_rdata), 64'(v.exp_rdata));
        check("rsp_flags", 64'({rsp_err, rsp_timeout}), 64'({v.exp_err, v.exp_to}));
        ok = 1'b1;
        for (int i = 0; i < v.rdly; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || psel !== 1'b0 || req_ready !== 1'b0 ||
                rsp_rdata !== v.exp_rdata || rsp_err !== v.exp_err ||
                rsp_timeout !== v.exp_to || paddr !== v.addr)
                ok = 1'b0;
        end
        if (v.rdly > 0) check("rsp_hold", 64'(ok), 64'd1);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("rsp_done", 64'({rsp_valid, req_ready, psel}), 64'(3'b010));
    endtask

    vec_t tbl[6];
    vec_t rv;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_write = 1'b0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        rsp_ready = 1'b0;
        pready    = 1'b0;
        prdata    = 32'hFFFF_FFFF;
        pslverr   = 1'b1;

        //          wr    addr          wdata         strb  prot  w   err   prdata        rdly  exp_rdata     err   to    acc
        tbl[0] = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, 3'd0, 0,  1'b0, 32'hAAAA_5555, 0,  32'h0,        1'b0, 1'b0, 1};
        tbl[1] = '{1'b0, 32'h0000_2004, 32'h1111_2222, 4'hF, 3'd2, 3,  1'b0, 32'h1234_5678, 1,  32'h1234_5678, 1'b0, 1'b0, 4};
        tbl[2] = '{1'b1, 32'h0000_3008, 32'h0BAD_F00D, 4'h3, 3'd1, 1,  1'b1, 32'h5555_AAAA, 0,  32'h0,        1'b1, 1'b0, 2};
        tbl[3] = '{1'b0, 32'h0000_400C, 32'h0,         4'h0, 3'd7, 20, 1'b0, 32'h7777_7777, 2,  32'h0,        1'b1, 1'b1, 4};
        tbl[4] = '{1'b0, 32'h0000_5010, 32'h9999_9999, 4'hA, 3'd4, 2,  1'b1, 32'hCAFE_F00D, 10, 32'hCAFE_F00D, 1'b1, 1'b0, 3};
        tbl[5] = '{1'b1, 32'h0000_6014, 32'h0102_0304, 4'h5, 3'd3, 3,  1'b0, 32'h0,         0,  32'h0,        1'b0, 1'b0, 4};

        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", 64'({req_ready, rsp_valid, psel, penable, pwrite, rsp_err, rsp_timeout}), 64'd0);
        check("reset_data", 64'({paddr, pwdata}), 64'd0);
        check("reset_misc", 64'({rsp_rdata, pstrb, pprot}), 64'd0);
        rst = 1'b0;

        foreach (tbl[i]) do_xfer(tbl[i]);

        // Reset in the middle of ACCESS drops the transfer without a response.
        req_write = 1'b1;
        req_addr  = 32'h0000_7018;
        req_wdata = 32'hFACE_FACE;
        req_strb  = 4'hF;
        req_prot  = 3'd5;
        req_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_access", 64'({psel, penable}), 64'(2'b11));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_ctl", 64'({req_ready, rsp_valid, psel, penable, pwrite, rsp_err, rsp_timeout}), 64'd0);
        check("mid_rst_data", 64'({paddr, pwdata}), 64'd0);
        begin
            logic quiet = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(posedge clk); #1;
                if (rsp_valid !== 1'b0 || psel !== 1'b0) quiet = 1'b0;
            end
            check("mid_rst_dropped", 64'(quiet), 64'd1);
        end
        do_xfer(tbl[1]);

        // Randomized transfers against the expectation model.
        for (int i = 0; i < 40; i++) begin
            rv.wr     = 1'($urandom);
            rv.addr   = $urandom;
            rv.wdata  = $urandom;
            rv.strb   = 4'($urandom);
            rv.prot   = 3'($urandom);
            rv.waits  = $urandom_range(0, 6);
            rv.slverr = 1'($urandom);
            rv.prdata = $urandom;
            rv.rdly   = $urandom_range(0, 3);
            do_xfer(model(rv));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
